// File: rtl/calc_input_stage.sv
// calc_input_stage: conditions raw board buttons and switches for the calc datapath.
//
// Every button and switch passes through a two-flop synchronizer. Each button is then
// debounced. A rising debounced btnd yields one op_valid strobe, and a rising debounced
// btnu yields one acc_clear strobe. Holding a button never repeats its strobe.
//
// Ports:
//   clk        system clock, rising edge
//   resetn     synchronous, active-low reset
//   btnc       raw centre button (opcode bit 1)
//   btnl       raw left button   (opcode bit 2)
//   btnu       raw up button     (accumulator clear request)
//   btnr       raw right button  (opcode bit 0)
//   btnd       raw down button   (apply operation)
//   sw[15:0]   raw operand switches (synchronized only, not debounced)
//   op_valid   one-cycle strobe: apply op_code/op_data
//   op_code    {btnl,btnc,btnr} debounced levels captured at the apply event
//   op_data    synchronized sw captured at the apply event
//   acc_clear  one-cycle strobe: clear accumulator
module calc_input_stage #(
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned CNT_W        = $clog2(DEBOUNCE_CNT + 1)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        btnc,
  input  logic        btnl,
  input  logic        btnu,
  input  logic        btnr,
  input  logic        btnd,
  input  logic [15:0] sw,
  output logic        op_valid,
  output logic [2:0]  op_code,
  output logic [15:0] op_data,
  output logic        acc_clear
);

  localparam int NumBtn = 5;
  // Bit positions of each button in the packed button vectors.
  localparam int BtnD = 0;
  localparam int BtnU = 1;
  localparam int BtnL = 2;
  localparam int BtnC = 3;
  localparam int BtnR = 4;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [NumBtn-1:0] btn_raw;
  assign btn_raw = {btnr, btnc, btnl, btnu, btnd};

  logic [NumBtn-1:0]            btn_s1_q, btn_s2_q;
  logic [NumBtn-1:0]            stable_q, stable_d;
  logic [NumBtn-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]                  sw_s1_q, sw_s2_q;
  logic                         prev_d_q, prev_u_q;
  logic                         rise_d, rise_u;

  logic        op_valid_q, op_valid_d;
  logic        acc_clear_q, acc_clear_d;
  logic [2:0]  op_code_q, op_code_d;
  logic [15:0] op_data_q, op_data_d;

  // Debounce: a level change needs DEBOUNCE_CNT consecutive mismatching cycles; any
  // matching cycle restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NumBtn; i++) begin
      cnt_d[i] = '0;
      if (btn_s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = btn_s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end
    end
  end

  assign rise_d = stable_q[BtnD] & ~prev_d_q;
  assign rise_u = stable_q[BtnU] & ~prev_u_q;

  // A clear event wins over a coincident apply event and leaves op_code/op_data alone.
  always_comb begin
    op_valid_d  = 1'b0;
    acc_clear_d = 1'b0;
    op_code_d   = op_code_q;
    op_data_d   = op_data_q;
    if (rise_u) begin
      acc_clear_d = 1'b1;
    end else if (rise_d) begin
      op_valid_d = 1'b1;
      op_code_d  = {stable_q[BtnL], stable_q[BtnC], stable_q[BtnR]};
      op_data_d  = sw_s2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      btn_s1_q    <= '0;
      btn_s2_q    <= '0;
      stable_q    <= '0;
      cnt_q       <= '0;
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
      prev_d_q    <= 1'b0;
      prev_u_q    <= 1'b0;
      op_valid_q  <= 1'b0;
      acc_clear_q <= 1'b0;
      op_code_q   <= '0;
      op_data_q   <= '0;
    end else begin
      btn_s1_q    <= btn_raw;
      btn_s2_q    <= btn_s1_q;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      sw_s1_q     <= sw;
      sw_s2_q     <= sw_s1_q;
      prev_d_q    <= stable_q[BtnD];
      prev_u_q    <= stable_q[BtnU];
      op_valid_q  <= op_valid_d;
      acc_clear_q <= acc_clear_d;
      op_code_q   <= op_code_d;
      op_data_q   <= op_data_d;
    end
  end

  assign op_valid  = op_valid_q;
  assign acc_clear = acc_clear_q;
  assign op_code   = op_code_q;
  assign op_data   = op_data_q;

endmodule
